smc_ustep_seq: RTL and testbench



---
 rtl/smc_ustep_seq.sv | 172 +++++++++++++++++
 tb/tb_smc_ustep_seq.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/smc_ustep_seq.sv
// Microstep sequencer: walks a 64-entry electrical phase and writes sine/cosine
// duty words for one motor's two coils into the smc duty registers.
module smc_ustep_seq #(
  parameter int MOTOR = 0
) (
  input  logic        QCLK,
  input  logic        QRESET,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_dir,
  input  logic [7:0]  cmd_steps,
  input  logic [15:0] cmd_rate,
  output logic        sm_sel,
  output logic        sm_write,
  output logic [6:0]  sm_addr,
  output logic [15:0] sm_wdata,
  output logic        busy,
  output logic        done,
  output logic [5:0]  pos
);

  localparam logic [6:0] ADDR_A = 7'(16 + 4 * MOTOR);
  localparam logic [6:0] ADDR_B = 7'(18 + 4 * MOTOR);

  typedef enum logic [2:0] {INIT_A, INIT_B, IDLE, WAIT, WR_A, WR_B} state_t;

  state_t      state_q, state_d;
  logic [5:0]  pos_q, pos_d;
  logic        dir_q, dir_d;
  logic [7:0]  steps_q, steps_d;
  logic [15:0] rate_q, rate_d;
  logic [15:0] wait_q, wait_d;
  logic        done_q, done_d;

  logic        bus_sel;
  logic [6:0]  bus_addr;
  logic [15:0] bus_data;
  logic [15:0] rate_clamp;

  // Quarter-wave table: round(2047*sin(k*pi/32)), k = 0..16.
  function automatic logic [10:0] sin_tab(input logic [4:0] k);
    case (k)
      5'd0:    sin_tab = 11'd0;
      5'd1:    sin_tab = 11'd201;
      5'd2:    sin_tab = 11'd399;
      5'd3:    sin_tab = 11'd594;
      5'd4:    sin_tab = 11'd783;
      5'd5:    sin_tab = 11'd965;
      5'd6:    sin_tab = 11'd1137;
      5'd7:    sin_tab = 11'd1299;
      5'd8:    sin_tab = 11'd1447;
      5'd9:    sin_tab = 11'd1582;
      5'd10:   sin_tab = 11'd1702;
      5'd11:   sin_tab = 11'd1805;
      5'd12:   sin_tab = 11'd1891;
      5'd13:   sin_tab = 11'd1959;
      5'd14:   sin_tab = 11'd2008;
      5'd15:   sin_tab = 11'd2037;
      5'd16:   sin_tab = 11'd2047;
      default: sin_tab = 11'd0;
    endcase
  endfunction

  // Odd quadrants read the table backwards; the lower half-cycle drives MNM,
  // except at a zero crossing where the sign would be meaningless.
  function automatic logic [15:0] duty(input logic [5:0] p);
    logic [10:0] mag;
    mag  = p[4] ? sin_tab(5'd16 - {1'b0, p[3:0]}) : sin_tab({1'b0, p[3:0]});
    duty = {p[5] && (mag != 11'd0), 4'b0000, mag};
  endfunction

  assign rate_clamp = (cmd_rate < 16'd4) ? 16'd4 : cmd_rate;

  always_comb begin
    state_d  = state_q;
    pos_d    = pos_q;
    dir_d    = dir_q;
    steps_d  = steps_q;
    rate_d   = rate_q;
    wait_d   = wait_q;
    done_d   = 1'b0;
    bus_sel  = 1'b0;
    bus_addr = 7'd0;
    bus_data = 16'd0;
    case (state_q)
      INIT_A: begin
        bus_sel  = 1'b1;
        bus_addr = ADDR_A;
        bus_data = duty(pos_q);
        state_d  = INIT_B;
      end
      INIT_B: begin
        bus_sel  = 1'b1;
        bus_addr = ADDR_B;
        bus_data = duty(pos_q + 6'd16);
        state_d  = IDLE;
      end
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_steps == 8'd0) begin
            done_d = 1'b1;
          end else begin
            dir_d   = cmd_dir;
            steps_d = cmd_steps;
            rate_d  = rate_clamp;
            wait_d  = rate_clamp - 16'd2;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (wait_q <= 16'd1) begin
          pos_d   = dir_q ? pos_q + 6'd1 : pos_q - 6'd1;
          state_d = WR_A;
        end else begin
          wait_d = wait_q - 16'd1;
        end
      end
      WR_A: begin
        bus_sel  = 1'b1;
        bus_addr = ADDR_A;
        bus_data = duty(pos_q);
        state_d  = WR_B;
      end
      WR_B: begin
        bus_sel  = 1'b1;
        bus_addr = ADDR_B;
        bus_data = duty(pos_q + 6'd16);
        steps_d  = steps_q - 8'd1;
        if (steps_q == 8'd1) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          wait_d  = rate_q - 16'd2;
          state_d = WAIT;
        end
      end
      default: state_d = INIT_A;
    endcase
  end

  always_ff @(posedge QCLK) begin
    if (QRESET) begin
      state_q <= INIT_A;
      pos_q   <= 6'd0;
      dir_q   <= 1'b0;
      steps_q <= 8'd0;
      rate_q  <= 16'd0;
      wait_q  <= 16'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      dir_q   <= dir_d;
      steps_q <= steps_d;
      rate_q  <= rate_d;
      wait_q  <= wait_d;
      done_q  <= done_d;
    end
  end

  // Outputs are forced quiet for as long as reset is held, not just after its edge.
  assign cmd_ready = !QRESET && (state_q == IDLE);
  assign busy      = !QRESET && (state_q != IDLE);
  assign done      = !QRESET && done_q;
  assign pos       = QRESET ? 6'd0 : pos_q;
  assign sm_sel    = !QRESET && bus_sel;
  assign sm_write  = !QRESET && bus_sel;
  assign sm_addr   = QRESET ? 7'd0 : bus_addr;
  assign sm_wdata  = QRESET ? 16'd0 : bus_data;

endmodule

// File: tb/tb_smc_ustep_seq.sv
// Bench for smc_ustep_seq: two instances (MOTOR 0 and 5) share stimulus and are
// compared every cycle against a schedule/trigonometry reference model.
module tb_smc_ustep_seq;

  logic        QCLK = 1'b0;
  logic        QRESET = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_dir = 1'b0;
  logic [7:0]  cmd_steps = 8'd0;
  logic [15:0] cmd_rate = 16'd0;

  logic        rdy0, busy0, done0, sel0, wr0;
  logic [6:0]  addr0;
  logic [15:0] wd0;
  logic [5:0]  pos0;
  logic        rdy5, busy5, done5, sel5, wr5;
  logic [6:0]  addr5;
  logic [15:0] wd5;
  logic [5:0]  pos5;
  logic [33:0] act0, act5;

  int checks = 0;
  int errors = 0;
  int model_pos = 0;

  always #5 QCLK = ~QCLK;

  smc_ustep_seq #(.MOTOR(0)) dut0 (
    .QCLK(QCLK), .QRESET(QRESET), .cmd_valid(cmd_valid), .cmd_ready(rdy0),
    .cmd_dir(cmd_dir), .cmd_steps(cmd_steps), .cmd_rate(cmd_rate),
    .sm_sel(sel0), .sm_write(wr0), .sm_addr(addr0), .sm_wdata(wd0),
    .busy(busy0), .done(done0), .pos(pos0)
  );

  smc_ustep_seq #(.MOTOR(5)) dut5 (
    .QCLK(QCLK), .QRESET(QRESET), .cmd_valid(cmd_valid), .cmd_ready(rdy5),
    .cmd_dir(cmd_dir), .cmd_steps(cmd_steps), .cmd_rate(cmd_rate),
    .sm_sel(sel5), .sm_write(wr5), .sm_addr(addr5), .sm_wdata(wd5),
    .busy(busy5), .done(done5), .pos(pos5)
  );

  assign act0 = {sel0, wr0, addr0, wd0, rdy0, busy0, done0, pos0};
  assign act5 = {sel5, wr5, addr5, wd5, rdy5, busy5, done5, pos5};

  // Duty word straight from the sine of the electrical angle, in sign-magnitude.
  function automatic logic [15:0] s_word(input int p);
    real v;
    int  mag;
    v   = 2047.0 * $sin(3.14159265358979 * (p % 64) / 32.0);
    mag = (v < 0.0) ? $rtoi(-v + 0.5) : $rtoi(v + 0.5);
    s_word = {(mag != 0) && (v < 0.0), 4'b0000, mag[10:0]};
  endfunction

  // Expected outputs in cycle c after a command was accepted.
  function automatic logic [33:0] exp_cmd(input int motor, input int c, input int steps,
                                          input int rate, input int p0, input bit dir);
    int L, n, p;
    bit a, b;
    logic [6:0]  addr;
    logic [15:0] wd;
    L = steps * rate;
    n = (c + 1) / rate;
    if (n > steps) n = steps;
    p = dir ? (p0 + n) % 64 : (((p0 - n) % 64) + 64) % 64;
    a = (c <= L) && (((c + 1) % rate) == 0);
    b = (c <= L) && (c > 0) && ((c % rate) == 0);
    addr = a ? 7'(16 + 4 * motor) : (b ? 7'(18 + 4 * motor) : 7'd0);
    wd   = a ? s_word(p) : (b ? s_word(p + 16) : 16'd0);
    exp_cmd = {a | b, a | b, addr, wd, c > L, c <= L, c == L + 1, 6'(p)};
  endfunction

  task automatic reset_and_init(input string name);
    logic [33:0] e0, e5;
    @(negedge QCLK);
    QRESET = 1'b1;
    cmd_valid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge QCLK);
      checks += 2;
      if (act0 !== 34'd0) begin
        errors++;
        $display("[TB] FAIL %s held dut0 got %h expected %h", name, act0, 34'd0);
      end
      if (act5 !== 34'd0) begin
        errors++;
        $display("[TB] FAIL %s held dut5 got %h expected %h", name, act5, 34'd0);
      end
    end
    @(posedge QCLK);
    #1 QRESET = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge QCLK);
      case (c)
        1: begin
          e0 = {1'b1, 1'b1, 7'h10, 16'h0000, 1'b0, 1'b1, 1'b0, 6'd0};
          e5 = {1'b1, 1'b1, 7'h24, 16'h0000, 1'b0, 1'b1, 1'b0, 6'd0};
        end
        2: begin
          e0 = {1'b1, 1'b1, 7'h12, 16'h07FF, 1'b0, 1'b1, 1'b0, 6'd0};
          e5 = {1'b1, 1'b1, 7'h26, 16'h07FF, 1'b0, 1'b1, 1'b0, 6'd0};
        end
        default: begin
          e0 = {1'b0, 1'b0, 7'h00, 16'h0000, 1'b1, 1'b0, 1'b0, 6'd0};
          e5 = e0;
        end
      endcase
      checks += 2;
      if (act0 !== e0) begin
        errors++;
        $display("[TB] FAIL %s init cycle %0d dut0 got %h expected %h", name, c, act0, e0);
      end
      if (act5 !== e5) begin
        errors++;
        $display("[TB] FAIL %s init cycle %0d dut5 got %h expected %h", name, c, act5, e5);
      end
    end
    model_pos = 0;
  endtask

  // Entered and left at a negedge inside a cycle where cmd_ready should be 1.
  task automatic run_cmd(input string name, input bit dir, input int steps,
                         input int rate, input int abort_at);
    int re, L, p0;
    logic [33:0] e0, e5;
    re = (rate < 4) ? 4 : rate;
    L  = steps * re;
    p0 = model_pos;
    checks++;
    if (rdy0 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s ready got %b expected 1", name, rdy0);
    end
    cmd_valid = 1'b1;
    cmd_dir   = dir;
    cmd_steps = 8'(steps);
    cmd_rate  = 16'(rate);
    for (int c = 1; c <= L + 1; c++) begin
      @(negedge QCLK);
      e0 = exp_cmd(0, c, steps, re, p0, dir);
      e5 = exp_cmd(5, c, steps, re, p0, dir);
      checks += 2;
      if (act0 !== e0) begin
        errors++;
        $display("[TB] FAIL %s cycle %0d dut0 got %h expected %h", name, c, act0, e0);
      end
      if (act5 !== e5) begin
        errors++;
        $display("[TB] FAIL %s cycle %0d dut5 got %h expected %h", name, c, act5, e5);
      end
      if (c < L) begin
        cmd_valid = 1'($urandom);
        cmd_dir   = 1'($urandom);
        cmd_steps = 8'($urandom);
        cmd_rate  = 16'($urandom);
      end else begin
        cmd_valid = 1'b0;
      end
      if (c == abort_at) begin
        QRESET = 1'b1;
        cmd_valid = 1'b0;
        return;
      end
    end
    model_pos = dir ? (p0 + steps) % 64 : (((p0 - steps) % 64) + 64) % 64;
  endtask

  task automatic test_reset;
    reset_and_init("reset");
  endtask

  task automatic test_forward_8;
    run_cmd("fwd8", 1'b1, 8, 10, 0);
    checks++;
    if (pos0 !== 6'd8) begin
      errors++;
      $display("[TB] FAIL fwd8_pos got %0d expected 8", pos0);
    end
  endtask

  task automatic test_reverse_wrap;
    reset_and_init("rev_reset");
    run_cmd("rev1", 1'b0, 1, 4, 0);
    checks++;
    if (pos0 !== 6'd63) begin
      errors++;
      $display("[TB] FAIL rev_pos got %0d expected 63", pos0);
    end
  endtask

  task automatic test_rate_clamp;
    reset_and_init("clamp_reset");
    run_cmd("clamp32", 1'b1, 32, 2, 0);
    checks++;
    if (pos0 !== 6'd32) begin
      errors++;
      $display("[TB] FAIL clamp_pos got %0d expected 32", pos0);
    end
  endtask

  task automatic test_back_to_back;
    run_cmd("zero", 1'($urandom), 0, int'($urandom_range(0, 20)), 0);
    run_cmd("b2b_a", 1'b0, 3, 5, 0);
    run_cmd("b2b_b", 1'b1, 2, 4, 0);
  endtask

  task automatic test_random;
    logic [33:0] e;
    int n;
    for (int i = 0; i < 25; i++) begin
      run_cmd("rand", 1'($urandom), int'($urandom_range(0, 12)),
              int'($urandom_range(0, 12)), 0);
      if ($urandom_range(0, 1) == 1) begin
        n = int'($urandom_range(1, 3));
        for (int k = 0; k < n; k++) begin
          @(negedge QCLK);
          e = {1'b0, 1'b0, 7'd0, 16'd0, 1'b1, 1'b0, 1'b0, 6'(model_pos)};
          checks++;
          if (act0 !== e) begin
            errors++;
            $display("[TB] FAIL rand_idle got %h expected %h", act0, e);
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    run_cmd("mid", 1'b1, 10, 6, 27);
    reset_and_init("mid_reset");
    checks += 2;
    if (pos0 !== 6'd0) begin
      errors++;
      $display("[TB] FAIL mid_pos0 got %0d expected 0", pos0);
    end
    if (pos5 !== 6'd0) begin
      errors++;
      $display("[TB] FAIL mid_pos5 got %0d expected 0", pos5);
    end
    run_cmd("post_mid", 1'b1, 2, 5, 0);
  endtask

  initial begin
    test_reset();
    test_forward_8();
    test_reverse_wrap();
    test_rate_clamp();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
